// File: rtl/hprime_pkg.sv
// Shared types, default sizes and saturation helpers for the hprime sequencer
// and its MAC datapath.
package hprime_pkg;

  localparam int DEF_N_IN  = 41;
  localparam int DEF_N_HID = 8;
  localparam int DEF_FRAC  = 16;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} state_t;

  typedef logic signed [31:0] word_t;
  typedef logic signed [47:0] acc_t;

  localparam word_t SAT_MAX = 32'sh7FFF_FFFF;
  localparam word_t SAT_MIN = 32'sh8000_0000;

  function automatic word_t saturate(input acc_t a);
    if (a > acc_t'(SAT_MAX)) return SAT_MAX;
    if (a < acc_t'(SAT_MIN)) return SAT_MIN;
    return word_t'(a);
  endfunction

endpackage

// File: rtl/hprime_sequencer_if.sv
// Bundle of the x input stream, weight ROM port and hprime output stream.
// master = sequencer side, slave = surrounding pipeline / ROM side.
interface hprime_sequencer_if
  import hprime_pkg::*;
#(
  parameter int W_AW = 9,
  parameter int IW   = 3
);
  logic            x_valid;
  logic            x_ready;
  word_t           x_data;
  logic [W_AW-1:0] w_addr;
  word_t           w_data;
  logic            h_valid;
  logic            h_ready;
  word_t           h_data;
  logic [IW-1:0]   h_index;
  logic            busy;

  modport master (
    input  x_valid, x_data, w_data, h_ready,
    output x_ready, w_addr, h_valid, h_data, h_index, busy
  );

  modport slave (
    output x_valid, x_data, w_data, h_ready,
    input  x_ready, w_addr, h_valid, h_data, h_index, busy
  );
endinterface

// File: rtl/hprime_mac.sv
// Shared multiply-accumulate: 32x32 signed product scaled by FRAC into a
// 48-bit accumulator, with clear, preload and saturated 32-bit read-out.
module hprime_mac
  import hprime_pkg::*;
#(
  parameter int FRAC = DEF_FRAC
) (
  input  logic  clock,
  input  logic  resetn,
  input  logic  clr,
  input  logic  ld,
  input  logic  en,
  input  word_t w,
  input  word_t x,
  output word_t sat
);
  logic signed [63:0] prod;
  acc_t               prod_sh;
  acc_t               acc;

  assign prod    = 64'(w) * 64'(x);
  assign prod_sh = acc_t'(prod >>> FRAC);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)  acc <= '0;
    else if (clr) acc <= '0;
    else if (ld)  acc <= acc_t'(w);
    else if (en)  acc <= acc + prod_sh;
  end

  assign sat = saturate(acc);
endmodule

// File: rtl/hprime_sequencer.sv
// Time-multiplexed hidden-layer pre-activation: buffers one x vector, walks
// every hidden unit through one MAC, streams hprime words. HPRIME_BIAS_EN adds a per-unit bias fetch.
module hprime_sequencer
  import hprime_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_HID = DEF_N_HID,
  parameter int FRAC  = DEF_FRAC,
  parameter int W_AW  = 9
) (
  input  logic                clock,
  input  logic                resetn,
  hprime_sequencer_if.master  bus
);
`ifdef HPRIME_BIAS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int ISSUES   = N_IN + LAT;
  localparam int MAC_LAST = ISSUES;
  localparam int CW = $clog2(MAC_LAST + 1);
  localparam int LW = $clog2(N_IN);
  localparam int UW = $clog2(N_HID);

  state_t          state_q, state_d;
  logic [UW-1:0]   unit_q, unit_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [LW-1:0]   lidx_q, lidx_d;
  logic [W_AW-1:0] addr_q, addr_d;
  logic            x_ready_q;
  logic            x_acc;
  logic            mac_clr, mac_ld, mac_en;
  logic [LW-1:0]   xi;
  word_t           xbuf [N_IN];

  // Issue c of unit u; with bias the bias word goes first, weights follow.
  function automatic logic [W_AW-1:0] addr_of(input int u, input int c);
`ifdef HPRIME_BIAS_EN
    if (c == 0) return W_AW'(N_HID * N_IN + u);
    return W_AW'(u * N_IN + c - 1);
`else
    return W_AW'(u * N_IN + c);
`endif
  endfunction

  assign x_acc = bus.x_valid && x_ready_q;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    cyc_d   = cyc_q;
    lidx_d  = lidx_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: if (x_acc) begin
        lidx_d  = LW'(1);
        state_d = LOAD;
      end
      LOAD: if (x_acc) begin
        if (lidx_q == LW'(N_IN - 1)) begin
          state_d = MAC;
          unit_d  = '0;
          cyc_d   = '0;
          lidx_d  = '0;
          addr_d  = addr_of(0, 0);
        end else begin
          lidx_d = lidx_q + 1'b1;
        end
      end
      MAC: begin
        if (cyc_q == CW'(MAC_LAST)) begin
          state_d = EMIT;
        end else begin
          cyc_d = cyc_q + 1'b1;
          if (int'(cyc_q) + 1 < ISSUES) addr_d = addr_of(int'(unit_q), int'(cyc_q) + 1);
        end
      end
      EMIT: if (bus.h_ready) begin
        cyc_d = '0;
        if (unit_q == UW'(N_HID - 1)) begin
          state_d = IDLE;
          unit_d  = '0;
        end else begin
          state_d = MAC;
          unit_d  = unit_q + 1'b1;
          addr_d  = addr_of(int'(unit_q) + 1, 0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      unit_q    <= '0;
      cyc_q     <= '0;
      lidx_q    <= '0;
      addr_q    <= '0;
      x_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      cyc_q     <= cyc_d;
      lidx_q    <= lidx_d;
      addr_q    <= addr_d;
      x_ready_q <= (state_d == IDLE) || (state_d == LOAD);
    end
  end

  // NOTE: the x buffer is plain storage with no reset; every element is
  // rewritten by LOAD before MAC reads it.
  always_ff @(posedge clock) begin
    if (x_acc) xbuf[lidx_q] <= bus.x_data;
  end

  // ROM data lags its address by one cycle, so the product pairs with x[cyc-1-LAT].
  always_comb begin
    mac_clr = (state_q == MAC) && (cyc_q == '0);
    mac_ld  = (LAT == 1) && (state_q == MAC) && (cyc_q == CW'(1));
    mac_en  = (state_q == MAC) && (int'(cyc_q) >= 1 + LAT);
    xi      = mac_en ? LW'(int'(cyc_q) - 1 - LAT) : '0;
  end

  hprime_mac #(.FRAC(FRAC)) u_mac (
    .clock  (clock),
    .resetn (resetn),
    .clr    (mac_clr),
    .ld     (mac_ld),
    .en     (mac_en),
    .w      (bus.w_data),
    .x      (xbuf[xi]),
    .sat    (bus.h_data)
  );

  assign bus.x_ready = x_ready_q;
  assign bus.w_addr  = addr_q;
  assign bus.h_valid = (state_q == EMIT);
  assign bus.h_index = unit_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_hprime_sequencer.sv
// Directed self-checking bench for hprime_sequencer with a synchronous weight
// ROM model; bias-specific steps run only when HPRIME_BIAS_EN is defined.
module tb_hprime_sequencer;
  import hprime_pkg::*;

  localparam int N_IN  = 41;
  localparam int N_HID = 8;
`ifdef HPRIME_BIAS_EN
  localparam int MAC_CYC  = 43;
  localparam int U4_ADDR  = 8 * 41 + 4;
`else
  localparam int MAC_CYC  = 42;
  localparam int U4_ADDR  = 4 * 41;
`endif

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] rom  [0:511];
  word_t       xv   [N_IN];
  logic [31:0] hexp [N_HID];

  hprime_sequencer_if #(.W_AW(9), .IW(3)) bus ();

  hprime_sequencer dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) bus.w_data <= rom[bus.w_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom(input logic [31:0] wv);
    for (int i = 0; i < 512; i++) rom[i] = (i < N_HID * N_IN) ? wv : 32'h0;
  endtask

  task automatic fill_x(input logic [31:0] v);
    for (int i = 0; i < N_IN; i++) xv[i] = v;
  endtask

  task automatic fill_h(input logic [31:0] v);
    for (int u = 0; u < N_HID; u++) hexp[u] = v;
  endtask

  // Offer the vector; stall toggles x_valid, keep leaves x_valid high afterwards.
  task automatic send_vec(input bit stall, input bit keep);
    int k = 0;
    int cyc = 0;
    bit tog = 1'b0;
    while (k < N_IN && cyc < 400) begin
      @(negedge clock);
      cyc++;
      tog = stall ? ~tog : 1'b1;
      bus.x_valid = tog;
      bus.x_data  = xv[k];
      if (tog && bus.x_ready) k++;
    end
    check("load_count", k, N_IN);
    @(negedge clock);
    if (keep) begin
      bus.x_valid = 1'b1;
      bus.x_data  = 32'hDEAD_BEEF;
    end else begin
      bus.x_valid = 1'b0;
    end
  endtask

  // Collect all hprime words; stall_unit (>=0) is held off with h_ready low for 10 cycles.
  task automatic get_outs(input int stall_unit);
    int u = 0;
    int cyc = 0;
    int hold = 0;
    int mac = 0;
    bit chk_next = 1'b0;
    while (u < N_HID && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (chk_next) begin
        check("next_unit_addr", bus.w_addr, U4_ADDR);
        chk_next = 1'b0;
      end
      if (bus.h_valid) begin
        if (u == stall_unit && hold < 10) begin
          bus.h_ready = 1'b0;
          hold++;
          check("bp_data", bus.h_data, hexp[u]);
          check("bp_index", bus.h_index, u);
          check("bp_addr", bus.w_addr, stall_unit * N_IN + N_IN - 1);
        end else begin
          check($sformatf("h_data[%0d]", u), bus.h_data, hexp[u]);
          check($sformatf("h_index[%0d]", u), bus.h_index, u);
          if (u == 1) check("mac_cycles", mac, MAC_CYC);
          if (u == stall_unit) chk_next = 1'b1;
          if (u == N_HID - 1) bus.x_valid = 1'b0;
          bus.h_ready = 1'b1;
          u++;
          mac = 0;
        end
      end else begin
        bus.h_ready = 1'b1;
        if (bus.busy) mac++;
      end
    end
    check("outputs_done", u, N_HID);
    @(negedge clock);
    check("idle_busy", bus.busy, 0);
    check("idle_x_ready", bus.x_ready, 1);
  endtask

  initial begin
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.h_ready = 1'b0;
    fill_rom(32'h0);

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_x_ready", bus.x_ready, 0);
    check("rst_h_valid", bus.h_valid, 0);
    check("rst_h_data", bus.h_data, 0);
    check("rst_h_index", bus.h_index, 0);
    check("rst_w_addr", bus.w_addr, 0);
    check("rst_busy", bus.busy, 0);
    resetn = 1'b1;
    @(negedge clock);
    check("post_rst_x_ready", bus.x_ready, 1);

    // Unit vector: 41 * (1.0 * 0.5) = 20.5
    fill_rom(32'h0000_8000);
    fill_x(32'h0001_0000);
    fill_h(32'h0014_8000);
    send_vec(1'b0, 1'b0);
    get_outs(-1);

    // Positive and negative saturation
    fill_rom(32'h7FFF_0000);
    fill_x(32'h7FFF_0000);
    fill_h(32'h7FFF_FFFF);
    send_vec(1'b0, 1'b0);
    get_outs(-1);
    fill_rom(32'h8001_0000);
    fill_h(32'h8000_0000);
    send_vec(1'b0, 1'b0);
    get_outs(-1);

    // Backpressure on unit 3 with x_valid held high: unit u picks x[5u] = (5u+1).0
    fill_rom(32'h0);
    for (int i = 0; i < N_IN; i++) xv[i] = word_t'((i + 1) << 16);
    for (int u = 0; u < N_HID; u++) begin
      rom[u * N_IN + 5 * u] = 32'h0001_0000;
      hexp[u] = (5 * u + 1) << 16;
    end
    send_vec(1'b0, 1'b1);
    get_outs(3);

    // Load stall: only element 40 contributes
    fill_rom(32'h0);
    for (int u = 0; u < N_HID; u++) rom[u * N_IN + 40] = 32'h0001_0000;
    fill_x(32'h1234_0000);
    xv[40] = 32'h0002_0000;
    fill_h(32'h0002_0000);
    send_vec(1'b1, 1'b0);
    get_outs(-1);

    // Reset while h_valid is held in EMIT drops h_valid asynchronously
    fill_rom(32'h0000_8000);
    fill_x(32'h0001_0000);
    fill_h(32'h0014_8000);
    send_vec(1'b0, 1'b0);
    bus.h_ready = 1'b0;
    repeat (45) @(negedge clock);
    check("emit_hold_valid", bus.h_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("async_h_valid", bus.h_valid, 0);
    check("async_busy", bus.busy, 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Reset mid-MAC, then a full vector must come out clean
    send_vec(1'b0, 1'b0);
    bus.h_ready = 1'b1;
    repeat (58) @(negedge clock);
    check("mid_mac_busy", bus.busy, 1);
    check("mid_mac_h_valid", bus.h_valid, 0);
    resetn = 1'b0;
    #1;
    check("mac_rst_busy", bus.busy, 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("rel_x_ready", bus.x_ready, 1);
    check("rel_busy", bus.busy, 0);
    check("rel_h_valid", bus.h_valid, 0);
    check("rel_w_addr", bus.w_addr, 0);
    send_vec(1'b0, 1'b0);
    get_outs(-1);

`ifdef HPRIME_BIAS_EN
    // Bias only: unit 5 carries -1.0, x all zero
    fill_rom(32'h0);
    rom[N_HID * N_IN + 5] = 32'hFFFF_0000;
    fill_x(32'h0);
    fill_h(32'h0);
    hexp[5] = 32'hFFFF_0000;
    send_vec(1'b0, 1'b0);
    get_outs(-1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
